boot_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the multicycle RV32I `cpu`. It accepts a framed byte stream (length, little-endian instruction words, checksum) and writes each assembled 32-bit word into the CPU's word-addressable unified memory through a dedicated write port. It holds the CPU in reset until the whole image has been written and verified. It replaces hierarchical memory preloading for both benches and hardware bring-up.

---
 rtl/boot_loader.sv | 147 ++++++++++++++
 tb/tb_boot_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Framed byte-stream loader: assembles little-endian words into CPU memory and holds the CPU
// in reset until the whole image is written and its checksum verified.
module boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic [7:0]          sum_q, sum_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;

  logic                accept;
  logic [15:0]         len_in;
  logic [31:0]         word_in;
  logic                overflow;
  logic                last_word;

  assign accept   = in_valid & in_ready;
  assign len_in   = {in_data, len_q[7:0]};
  // Bytes shift in from the top so byte0 ends up in [7:0] after four shifts.
  assign word_in  = {in_data, word_q[31:8]};
  assign overflow = {16'h0000, len_in} > (32'd1 << ADDR_W);
  assign last_word = (32'(word_cnt_q) + 32'd1) == {16'h0000, len_q};

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLenLo;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLenLo: if (accept) state_d = StLenHi;
      StLenHi: begin
        if (accept) begin
          if (overflow)            state_d = StErr;
          else if (len_in == '0)   state_d = StChk;
          else                     state_d = StData;
        end
      end
      StData:  if (accept && byte_idx_q == 2'd3 && last_word) state_d = StChk;
      StChk:   if (accept) state_d = (in_data == sum_q) ? StDone : StErr;
      StDone:  state_d = StDone;
      StErr:   state_d = StErr;
      default: state_d = StLenLo;
    endcase
  end

  // Datapath next-state: length capture, word assembly, checksum and write strobe.
  always_comb begin
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (accept) begin
      if (state_q == StLenLo) begin
        len_d = {8'h00, in_data};
      end else if (state_q == StLenHi) begin
        len_d = len_in;
      end else if (state_q == StData) begin
        word_d     = word_in;
        sum_d      = sum_q + in_data;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_cnt_q[ADDR_W-1:0];
          mem_wdata_d = word_in;
          word_cnt_d  = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        end
      end
    end
    cpu_rst_d = (state_d != StDone);
  end

  // Outputs.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData, StChk: in_ready = 1'b1;
      StDone:  done = 1'b1;
      StErr:   err  = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (ADDR_W=8 and ADDR_W=2) checked every cycle against a
// byte-position model of the frame, plus literal checks on the directed loads.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       sel = 1'b0;  // 0: ADDR_W=8 instance, 1: ADDR_W=2 instance

  always #5 clk = ~clk;

  logic        v8, r8, we8, cr8, dn8, er8;
  logic [7:0]  a8;
  logic [31:0] d8;
  logic        v2, r2, we2, cr2, dn2, er2;
  logic [1:0]  a2;
  logic [31:0] d2;

  assign v8 = in_valid & ~sel;
  assign v2 = in_valid & sel;

  boot_loader #(.ADDR_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_data(in_data), .in_ready(r8), .mem_we(we8),
    .mem_addr(a8), .mem_wdata(d8), .cpu_rst(cr8), .done(dn8), .err(er8)
  );

  boot_loader #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(in_data), .in_ready(r2), .mem_we(we2),
    .mem_addr(a2), .mem_wdata(d2), .cpu_rst(cr2), .done(dn2), .err(er2)
  );

  logic        o_ready, o_we, o_cpu_rst, o_done, o_err;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;
  assign o_ready   = sel ? r2 : r8;
  assign o_we      = sel ? we2 : we8;
  assign o_addr    = sel ? {6'b0, a2} : a8;
  assign o_wdata   = sel ? d2 : d8;
  assign o_cpu_rst = sel ? cr2 : cr8;
  assign o_done    = sel ? dn2 : dn8;
  assign o_err     = sel ? er2 : er8;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame interpreted by byte position p (0,1 length; 2..4N+1 data; 4N+2 checksum).
  int          aw, p, len, sum, q;
  logic [31:0] cur;
  bit          m_done, m_err, m_we, acc;
  int          m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  bd;

  logic [7:0]  log_a[$];
  logic [31:0] log_d[$];

  task automatic model_step(input logic [7:0] d);
    if (p == 0) begin
      len = int'(d);
      p = 1;
    end else if (p == 1) begin
      len = len + int'(d) * 256;
      if (len > (1 << aw)) m_err = 1;
      else p = 2;
    end else if (p < 4 * len + 2) begin
      q = p - 2;
      cur = cur | (32'(d) << (8 * (q % 4)));
      sum = (sum + int'(d)) % 256;
      if (q % 4 == 3) begin
        m_we = 1;
        m_addr = (q / 4) % (1 << aw);
        m_wdata = cur;
        cur = 0;
      end
      p++;
    end else begin
      if (int'(d) == sum) m_done = 1;
      else m_err = 1;
    end
  endtask

  always @(posedge clk) begin
    aw   = sel ? 2 : 8;
    acc  = in_valid && !m_done && !m_err;
    bd   = in_data;
    m_we = 0;
    if (rst) begin
      p = 0; len = 0; sum = 0; cur = 0;
      m_done = 0; m_err = 0; m_addr = 0; m_wdata = 0;
    end else if (acc) begin
      model_step(bd);
    end
    #1;
    chk("in_ready", {31'b0, o_ready}, {31'b0, !(m_done || m_err)});
    chk("mem_we", {31'b0, o_we}, {31'b0, m_we});
    chk("mem_addr", {24'b0, o_addr}, {24'b0, 8'(m_addr)});
    chk("mem_wdata", o_wdata, m_wdata);
    chk("done", {31'b0, o_done}, {31'b0, m_done});
    chk("err", {31'b0, o_err}, {31'b0, m_err});
    chk("cpu_rst", {31'b0, o_cpu_rst}, {31'b0, !m_done});
    if (o_we === 1'b1) begin
      log_a.push_back(o_addr);
      log_d.push_back(o_wdata);
    end
  end

  logic [7:0] fq[$];

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // Sends the first `cut` bytes of fq with gaps of gap_lo..gap_hi idle cycles after each.
  task automatic send_frame(input int gap_lo, input int gap_hi, input int cut);
    for (int i = 0; i < fq.size() && i < cut; i++) begin
      send_byte(fq[i]);
      idle(int'($urandom_range(gap_hi, gap_lo)));
    end
    idle(2);
  endtask

  task automatic build(input int n, input bit good);
    int s;
    logic [7:0] b;
    fq.delete();
    s = 0;
    fq.push_back(8'(n));
    fq.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      s = (s + int'(b)) % 256;
      fq.push_back(b);
    end
    if (good) fq.push_back(8'(s));
    else fq.push_back(8'(s) + 8'($urandom_range(255, 1)));
  endtask

  task automatic do_reset(input logic new_sel);
    rst = 1'b1;
    in_valid = 1'b0;
    sel = new_sel;
    @(negedge clk);
    rst = 1'b0;
    log_a.delete();
    log_d.delete();
  endtask

  logic [7:0]  nom[23] = '{8'h05, 8'h00,
                           8'h93, 8'h00, 8'ha0, 8'h00, 8'h13, 8'h01, 8'h40, 8'h01,
                           8'hb3, 8'h81, 8'h20, 8'h00, 8'h23, 8'h24, 8'h30, 8'h02,
                           8'h03, 8'h22, 8'h80, 8'h02, 8'hfc};
  logic [31:0] nomw[5] = '{32'h00a00093, 32'h01400113, 32'h002081b3, 32'h02302423,
                           32'h02802203};

  task automatic load_nom(input logic [7:0] chk_byte);
    fq.delete();
    for (int i = 0; i < 22; i++) fq.push_back(nom[i]);
    fq.push_back(chk_byte);
  endtask

  task automatic check_nom_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(log_a.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_a.size(); i++) begin
      chk({tag, "_addr"}, {24'b0, log_a[i]}, 32'(i));
      chk({tag, "_data"}, log_d[i], nomw[i]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Nominal back-to-back load.
    do_reset(1'b0);
    load_nom(8'hfc);
    send_frame(0, 0, 1000);
    check_nom_writes("nominal");
    chk("nominal_done", {31'b0, o_done}, 32'd1);
    chk("nominal_cpu_rst", {31'b0, o_cpu_rst}, 32'd0);
    chk("model_done", {31'b0, m_done}, 32'd1);

    // Terminal hold: bytes offered after done are refused.
    in_valid = 1'b1;
    idle(10);
    in_valid = 1'b0;
    idle(1);
    chk("hold_nwrites", 32'(log_a.size()), 32'd5);
    chk("hold_done", {31'b0, o_done}, 32'd1);

    // Gapped stream.
    do_reset(1'b0);
    load_nom(8'hfc);
    send_frame(3, 3, 1000);
    check_nom_writes("gapped");
    chk("gapped_done", {31'b0, o_done}, 32'd1);

    // Checksum error.
    do_reset(1'b0);
    load_nom(8'hfb);
    send_frame(0, 0, 1000);
    check_nom_writes("badsum");
    chk("badsum_err", {31'b0, o_err}, 32'd1);
    chk("badsum_done", {31'b0, o_done}, 32'd0);
    chk("badsum_cpu_rst", {31'b0, o_cpu_rst}, 32'd1);
    chk("badsum_ready", {31'b0, o_ready}, 32'd0);

    // Empty image.
    do_reset(1'b0);
    fq = '{8'h00, 8'h00, 8'h00};
    send_frame(0, 0, 1000);
    chk("empty_nwrites", 32'(log_a.size()), 32'd0);
    chk("empty_done", {31'b0, o_done}, 32'd1);

    // ADDR_W=2: full-size image, then one word too many.
    do_reset(1'b1);
    build(4, 1'b1);
    send_frame(0, 1, 1000);
    chk("full_nwrites", 32'(log_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) chk("full_addr", {24'b0, log_a[i]}, 32'(i));
    chk("full_done", {31'b0, o_done}, 32'd1);
    do_reset(1'b1);
    build(5, 1'b1);
    send_frame(0, 0, 1000);
    chk("ovf_nwrites", 32'(log_a.size()), 32'd0);
    chk("ovf_err", {31'b0, o_err}, 32'd1);

    // Reset mid-load, then a fresh one-word frame.
    do_reset(1'b0);
    load_nom(8'hfc);
    send_frame(0, 0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fq = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h0e};
    send_frame(0, 0, 1000);
    chk("midrst_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("midrst_addr", {24'b0, log_a[1]}, 32'd0);
      chk("midrst_data", log_d[1], 32'hddccbbaa);
    end
    chk("midrst_done", {31'b0, o_done}, 32'd1);

    // Randomised frames on both instances, with occasional truncation.
    for (int it = 0; it < 60; it++) begin
      do_reset(1'($urandom));
      build(int'($urandom_range(sel ? 5 : 7, 0)), ($urandom_range(3, 0) != 0));
      send_frame(0, int'($urandom_range(2, 0)),
                 ($urandom_range(4, 0) == 0) ? int'($urandom_range(30, 0)) : 1000);
      in_valid = 1'b1;
      idle(int'($urandom_range(3, 0)));
      in_valid = 1'b0;
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
